// File: rtl/alu_pkg.sv
// Shared ALU/condition definitions: condition codes, NZCV bit positions
// and ALU control encodings used by both the ALU and the condition unit.
package alu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_e;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluation: Cond field against stored NZCV flags.
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = Flags[FLAG_N];
    assign w_z  = Flags[FLAG_Z];
    assign w_c  = Flags[FLAG_C];
    assign w_v  = Flags[FLAG_V];
    assign w_ge = (w_n == w_v);

    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: CondEx = w_z;
            COND_NE: CondEx = !w_z;
            COND_CS: CondEx = w_c;
            COND_CC: CondEx = !w_c;
            COND_MI: CondEx = w_n;
            COND_PL: CondEx = !w_n;
            COND_VS: CondEx = w_v;
            COND_VC: CondEx = !w_v;
            COND_HI: CondEx = w_c && !w_z;
            COND_LS: CondEx = !w_c || w_z;
            COND_GE: CondEx = w_ge;
            COND_LT: CondEx = !w_ge;
            COND_GT: CondEx = !w_z && w_ge;
            COND_LE: CondEx = w_z || !w_ge;
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// NZCV flag register, condition gating of write/branch controls and
// saturating executed/skipped instruction counters.
module cond_unit
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             cnt_clr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] skip_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_exec;
    logic [CNT_W-1:0] r_skip;
    logic             w_cond_ex;
    logic             w_exec;
    logic             w_skip;

    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (r_flags),
        .CondEx (w_cond_ex)
    );

    assign w_exec = valid && w_cond_ex;
    assign w_skip = valid && !w_cond_ex;

    assign CondEx   = w_cond_ex;
    assign PCSrc    = w_exec && PCS;
    assign RegWrite = w_exec && RegW && !NoWrite;
    assign MemWrite = w_exec && MemW;

    assign Flags      = r_flags;
    assign exec_count = r_exec;
    assign skip_count = r_skip;

    // N,Z and C,V halves load independently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_exec) begin
            if (FlagW[1]) r_flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Clear has priority over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exec <= '0;
            r_skip <= '0;
        end else if (cnt_clr) begin
            r_exec <= '0;
            r_skip <= '0;
        end else begin
            if (w_exec && (r_exec != '1)) r_exec <= r_exec + CNT_ONE;
            if (w_skip && (r_skip != '1)) r_skip <= r_skip + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: a 16-bit-counter and a 4-bit-counter
// instance driven by the same stimulus.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite, cnt_clr;

    logic        pcsrc_a, regwr_a, memwr_a, condex_a;
    logic [3:0]  flags_a;
    logic [15:0] exec_a, skip_a;
    logic        pcsrc_b, regwr_b, memwr_b, condex_b;
    logic [3:0]  flags_b;
    logic [3:0]  exec_b, skip_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cond_unit #(.CNT_W(16)) dut16 (
        .clk(clk), .reset(reset), .valid(valid), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .cnt_clr(cnt_clr), .PCSrc(pcsrc_a), .RegWrite(regwr_a), .MemWrite(memwr_a),
        .CondEx(condex_a), .Flags(flags_a), .exec_count(exec_a), .skip_count(skip_a)
    );

    cond_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .valid(valid), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .cnt_clr(cnt_clr), .PCSrc(pcsrc_b), .RegWrite(regwr_b), .MemWrite(memwr_b),
        .CondEx(condex_b), .Flags(flags_b), .exec_count(exec_b), .skip_count(skip_b)
    );

    task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                         input logic [3:0] af, input logic p, input logic r,
                         input logic m, input logic nw);
        valid = v; Cond = c; FlagW = fw; ALUFlags = af;
        PCS = p; RegW = r; MemW = m; NoWrite = nw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cnt_clr = 1'b0;
        drive(1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        total++; if (flags_a !== 4'b0000) $display("FAIL reset_flags got %b want 0000", flags_a); else passed++;
        total++; if (exec_a !== 16'd0) $display("FAIL reset_exec got %0d want 0", exec_a); else passed++;
        total++; if (skip_a !== 16'd0) $display("FAIL reset_skip got %0d want 0", skip_a); else passed++;
        total++; if (condex_a !== 1'b0) $display("FAIL reset_condex got %b want 0", condex_a); else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_al_update();
        drive(1'b1, 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        total++; if (condex_a !== 1'b1) $display("FAIL al_condex got %b want 1", condex_a); else passed++;
        step();
        total++; if (flags_a !== 4'b0100) $display("FAIL al_flags got %b want 0100", flags_a); else passed++;
        total++; if (exec_a !== 16'd1) $display("FAIL al_exec got %0d want 1", exec_a); else passed++;
        total++; if (exec_b !== 4'd1) $display("FAIL al_exec4 got %0d want 1", exec_b); else passed++;
    endtask

    task automatic test_eq_ne();
        drive(1'b1, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        total++; if (regwr_a !== 1'b1) $display("FAIL eq_regwrite got %b want 1", regwr_a); else passed++;
        total++; if (memwr_a !== 1'b1) $display("FAIL eq_memwrite got %b want 1", memwr_a); else passed++;
        total++; if (pcsrc_a !== 1'b1) $display("FAIL eq_pcsrc got %b want 1", pcsrc_a); else passed++;
        step();
        drive(1'b1, 4'b0001, 2'b11, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        total++; if ({pcsrc_a, regwr_a, memwr_a, condex_a} !== 4'b0000)
            $display("FAIL ne_gated got %b want 0000", {pcsrc_a, regwr_a, memwr_a, condex_a}); else passed++;
        step();
        total++; if (skip_a !== 16'd1) $display("FAIL ne_skip got %0d want 1", skip_a); else passed++;
        total++; if (flags_a !== 4'b0100) $display("FAIL ne_flags got %b want 0100", flags_a); else passed++;
        total++; if (exec_a !== 16'd2) $display("FAIL ne_exec got %0d want 2", exec_a); else passed++;
    endtask

    task automatic test_partial();
        drive(1'b1, 4'b1110, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        total++; if (flags_a !== 4'b0000) $display("FAIL part_zero got %b want 0000", flags_a); else passed++;
        drive(1'b1, 4'b1110, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        total++; if (flags_a !== 4'b1100) $display("FAIL part_nz got %b want 1100", flags_a); else passed++;
        drive(1'b1, 4'b1110, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        total++; if (flags_a !== 4'b1111) $display("FAIL part_cv got %b want 1111", flags_a); else passed++;
        total++; if (exec_a !== 16'd5) $display("FAIL part_exec got %0d want 5", exec_a); else passed++;
    endtask

    task automatic test_signed();
        logic [3:0] codes [7];
        logic       want  [7];
        codes = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1000, 4'b1001, 4'b1111};
        want  = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b0};
        // N=1 Z=0 C=1 V=0
        drive(1'b1, 4'b1110, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        total++; if (flags_a !== 4'b1010) $display("FAIL sgn_flags got %b want 1010", flags_a); else passed++;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, codes[i], 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            total++; if (condex_a !== want[i])
                $display("FAIL sgn_cond%b got %b want %b", codes[i], condex_a, want[i]); else passed++;
        end
    endtask

    task automatic test_compare_invalid();
        drive(1'b1, 4'b1110, 2'b11, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        total++; if (regwr_a !== 1'b0) $display("FAIL cmp_regwrite got %b want 0", regwr_a); else passed++;
        step();
        total++; if (flags_a !== 4'b0110) $display("FAIL cmp_flags got %b want 0110", flags_a); else passed++;
        total++; if (exec_a !== 16'd7) $display("FAIL cmp_exec got %0d want 7", exec_a); else passed++;
        drive(1'b0, 4'b1110, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        total++; if ({pcsrc_a, regwr_a, memwr_a} !== 3'b000)
            $display("FAIL inv_gated got %b want 000", {pcsrc_a, regwr_a, memwr_a}); else passed++;
        step();
        total++; if (flags_a !== 4'b0110) $display("FAIL inv_flags got %b want 0110", flags_a); else passed++;
        total++; if (exec_a !== 16'd7 || skip_a !== 16'd1)
            $display("FAIL inv_counts got %0d/%0d want 7/1", exec_a, skip_a); else passed++;
    endtask

    task automatic test_saturate();
        drive(1'b1, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        total++; if (exec_b !== 4'd15) $display("FAIL sat_exec4 got %0d want 15", exec_b); else passed++;
        total++; if (exec_a !== 16'd27) $display("FAIL sat_exec16 got %0d want 27", exec_a); else passed++;
        total++; if (skip_b !== 4'd1) $display("FAIL sat_skip4 got %0d want 1", skip_b); else passed++;
    endtask

    task automatic test_clear();
        cnt_clr = 1'b1;
        drive(1'b1, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        cnt_clr = 1'b0;
        total++; if (exec_b !== 4'd0 || skip_b !== 4'd0)
            $display("FAIL clr_counts4 got %0d/%0d want 0/0", exec_b, skip_b); else passed++;
        total++; if (exec_a !== 16'd0 || skip_a !== 16'd0)
            $display("FAIL clr_counts16 got %0d/%0d want 0/0", exec_a, skip_a); else passed++;
        total++; if (flags_a !== 4'b0110) $display("FAIL clr_flags got %b want 0110", flags_a); else passed++;
        step();
        total++; if (exec_b !== 4'd1) $display("FAIL clr_resume got %0d want 1", exec_b); else passed++;
    endtask

    task automatic test_async_reset();
        drive(1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        total++; if (flags_a !== 4'b0000) $display("FAIL arst_flags got %b want 0000", flags_a); else passed++;
        total++; if (exec_b !== 4'd0) $display("FAIL arst_exec got %0d want 0", exec_b); else passed++;
        #1;
        reset = 1'b0;
        drive(1'b1, 4'b1110, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        total++; if (flags_a !== 4'b1001) $display("FAIL arst_post_flags got %b want 1001", flags_a); else passed++;
        total++; if (exec_a !== 16'd1) $display("FAIL arst_post_exec got %0d want 1", exec_a); else passed++;
    endtask

    initial begin
        test_reset();
        test_al_update();
        test_eq_ne();
        test_partial();
        test_signed();
        test_compare_invalid();
        test_saturate();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
